// File: rtl/rr_arbiter_four.sv
// rtl/rr_arbiter_four.sv - four-client round-robin arbiter with hold-time limit
//
// Purpose: grants one shared resource to one of four requesters in rotating
// priority order, limits each grant to MAX_HOLD cycles and inserts one idle
// turnaround cycle between consecutive grants.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   level-sensitive request, bit i = client i
//   release_i  current owner is finished (only looked at while granting)
//   gnt[3:0]   one-hot grant, decode(gnt_idx) while gnt_vld, else 0
//   gnt_idx    current/last owner index
//   gnt_vld    grant active (equals |gnt)
//   tmo        one-cycle pulse in the gap that follows a hold-limit timeout
module rr_arbiter_four #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       release_i,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       tmo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // cnt counts 0..MAX_HOLD-1 across the grant, so the grant ends on the
    // edge that closes its MAX_HOLD-th cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       tmo_q, tmo_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       end_rel;
    logic       end_drop;
    logic       end_tmo;

    function automatic logic [3:0] decode(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Priority search starting at ptr; 2-bit addition gives the mod-4 wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = 4'b0000;
        gnt_vld_d = 1'b0;
        tmo_d     = 1'b0;

        end_rel  = release_i;
        end_drop = !req[gnt_idx_q];
        end_tmo  = (cnt_q == HOLD_LAST);

        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_found) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = win_idx;
                    cnt_d     = 8'd0;
                    gnt_d     = decode(win_idx);
                    gnt_vld_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (end_rel || end_drop || end_tmo) begin
                    state_d = ST_GAP;
                    ptr_d   = gnt_idx_q + 2'd1;
                    // Release and request drop take precedence over timeout.
                    tmo_d   = end_tmo && !end_rel && !end_drop;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    gnt_d     = gnt_q;
                    gnt_vld_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            gnt_q     <= 4'b0000;
            gnt_idx_q <= 2'd0;
            gnt_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_q     <= tmo_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_four.sv
// tb/tb_rr_arbiter_four.sv - randomized bench for rr_arbiter_four against a behavioural model
module tb_rr_arbiter_four;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       release_i;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       tmo;

    rr_arbiter_four #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .release_i (release_i),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld),
        .tmo       (tmo)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference: who owns the resource, for how many cycles, and which client
    // is first in line once the resource is free again.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_held  = 0;
    int m_next  = 0;
    bit m_tmo   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rl, input logic rs);
        if (rs) begin
            m_busy  = 0;
            m_owner = 0;
            m_held  = 0;
            m_next  = 0;
            m_tmo   = 0;
        end else if (m_busy) begin
            m_held++;
            if (rl || !r[m_owner] || m_held >= MAX_HOLD) begin
                m_tmo  = !rl && r[m_owner];
                m_busy = 0;
                m_next = (m_owner + 1) % 4;
            end else begin
                m_tmo = 0;
            end
        end else begin
            m_tmo = 0;
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && r[(m_next + k) % 4]) begin
                    m_busy  = 1;
                    m_owner = (m_next + k) % 4;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rl, input logic rs);
        logic [3:0] exp_gnt;
        req       = r;
        release_i = rl;
        rst       = rs;
        @(posedge clk);
        model_edge(r, rl, rs);
        @(negedge clk);
        exp_gnt = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        check_eq("gnt",     32'(gnt),     32'(exp_gnt));
        check_eq("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        check_eq("gnt_vld", 32'(gnt_vld), 32'(m_busy));
        check_eq("tmo",     32'(tmo),     32'(m_tmo));
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b1111;
        release_i = 1'b0;

        // reset with all clients requesting
        for (int i = 0; i < 2; i++) step(4'b1111, 1'b0, 1'b1);

        // fairness: everyone requests, release on third grant cycle
        for (int i = 0; i < 20; i++) step(4'b1111, (dut.gnt_vld && m_held == 2), 1'b0);

        // sparse clients 1 and 3
        for (int i = 0; i < 12; i++) step(4'b1010, 1'b1, 1'b0);

        // single requester, timeout then released on last cycle
        for (int i = 0; i < 30; i++) step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(4'b0100, (m_busy && m_held == MAX_HOLD - 1), 1'b0);

        // rotating timeouts with everyone requesting
        for (int i = 0; i < 40; i++) step(4'b1111, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(4'($urandom), ($urandom_range(0, 5) == 0), 1'b0);

        // random traffic with occasional mid-grant reset
        for (int i = 0; i < 300; i++)
            step(4'($urandom) | 4'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 40) == 0));

        // reset then all request: client 0 first
        step(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b1111, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
